// File: rtl/rgmii_udp_tx_framer.sv
// Ethernet/IPv4/UDP transmit framer: wraps a payload byte stream with preamble, SFD,
// a 42-byte header, zero pad and FCS, and drives a GMII byte interface.
module rgmii_udp_tx_framer #(
  parameter int         IFG_BYTES = 12,
  parameter logic [7:0] TTL       = 8'h40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [47:0] fpga_mac_i,
  input  logic [47:0] host_mac_i,
  input  logic [31:0] fpga_ip_i,
  input  logic [31:0] host_ip_i,
  input  logic [15:0] fpga_port_i,
  input  logic [15:0] host_port_i,
  input  logic [15:0] payload_bytes_i,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  gmii_txd_o,
  output logic        gmii_tx_en_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        underrun_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_HDR  = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;
  localparam logic [2:0] S_PAD  = 3'd5;
  localparam logic [2:0] S_FCS  = 3'd6;
  localparam logic [2:0] S_IFG  = 3'd7;

  logic [2:0]   state;
  logic [15:0]  cnt;
  logic [15:0]  ident;
  logic [47:0]  mac_src, mac_dst;
  logic [31:0]  ip_src, ip_dst;
  logic [15:0]  port_src, port_dst, len;
  logic [15:0]  csum;
  logic [31:0]  crc;
  logic [15:0]  total_len, udp_len;
  logic [335:0] hdr;
  logic [8:0]   hsel;
  logic [7:0]   tx_byte;
  logic         start, ifg_last;
  logic         unused_tlast;

  function automatic logic [15:0] ip_csum(input logic [15:0] tl, input logic [15:0] id,
                                          input logic [31:0] src, input logic [31:0] dst);
    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;
    sum = 20'h04500 + {4'h0, tl} + {4'h0, id} + 20'h04000 + {4'h0, TTL, 8'h11}
        + {4'h0, src[31:16]} + {4'h0, src[15:0]} + {4'h0, dst[31:16]} + {4'h0, dst[15:0]};
    fold1 = {1'b0, sum[15:0]} + {13'h0, sum[19:16]};
    fold2 = fold1[15:0] + {15'h0, fold1[16]};
    return ~fold2;
  endfunction

  // Reflected CRC-32, data bits consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign unused_tlast = s_axis_tlast;
  assign total_len    = len + 16'd28;
  assign udp_len      = len + 16'd8;
  assign hdr = {mac_dst, mac_src, 16'h0800, 16'h4500, total_len, ident, 16'h4000,
                TTL, 8'h11, csum, ip_src, ip_dst, port_src, port_dst, udp_len, 16'h0000};
  assign hsel     = 9'd335 - {cnt[5:0], 3'b000};
  assign ifg_last = (state == S_IFG) && (cnt == 16'(IFG_BYTES - 1));
  // The last IFG cycle doubles as a start opportunity so back-to-back frames keep exact spacing.
  assign start    = s_axis_tvalid && ((state == S_IDLE) || ifg_last);

  always_comb begin
    tx_byte       = 8'h00;
    gmii_tx_en_o  = 1'b0;
    s_axis_tready = 1'b0;
    underrun_o    = 1'b0;
    frame_done_o  = 1'b0;
    case (state)
      S_PRE: begin tx_byte = 8'h55; gmii_tx_en_o = 1'b1; end
      S_SFD: begin tx_byte = 8'hD5; gmii_tx_en_o = 1'b1; end
      S_HDR: begin tx_byte = hdr[hsel -: 8]; gmii_tx_en_o = 1'b1; end
      S_PAY: begin
        gmii_tx_en_o  = 1'b1;
        s_axis_tready = 1'b1;
        tx_byte       = s_axis_tvalid ? s_axis_tdata : 8'h00;
        underrun_o    = ~s_axis_tvalid;
      end
      S_PAD: gmii_tx_en_o = 1'b1;
      S_FCS: begin
        gmii_tx_en_o = 1'b1;
        tx_byte      = ~crc[{cnt[1:0], 3'b000} +: 8];
        frame_done_o = (cnt == 16'd3);
      end
      default: ;
    endcase
  end

  assign gmii_txd_o = tx_byte;
  assign busy_o     = (state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= 16'd0;
      ident <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
      case (state)
        S_IDLE: begin
          cnt <= 16'd0;
          if (start) state <= S_PRE;
        end
        S_PRE: if (cnt == 16'd6) begin state <= S_SFD; cnt <= 16'd0; end
        S_SFD: begin state <= S_HDR; cnt <= 16'd0; end
        S_HDR: if (cnt == 16'd41) begin state <= S_PAY; cnt <= 16'd0; end
        S_PAY: if (cnt == len - 16'd1) begin
          state <= (len < 16'd18) ? S_PAD : S_FCS;
          cnt   <= 16'd0;
        end
        S_PAD: if (cnt == 16'd17 - len) begin state <= S_FCS; cnt <= 16'd0; end
        S_FCS: if (cnt == 16'd3) begin
          state <= S_IFG;
          cnt   <= 16'd0;
          ident <= ident + 16'd1;
        end
        S_IFG: if (ifg_last) begin
          state <= start ? S_PRE : S_IDLE;
          cnt   <= 16'd0;
        end
        default: begin state <= S_IDLE; cnt <= 16'd0; end
      endcase
    end
  end

  // Config snapshot, checksum (ready well before its header slot) and running CRC.
  always_ff @(posedge clk_i) begin
    if (start) begin
      mac_src  <= fpga_mac_i;
      mac_dst  <= host_mac_i;
      ip_src   <= fpga_ip_i;
      ip_dst   <= host_ip_i;
      port_src <= fpga_port_i;
      port_dst <= host_port_i;
      len      <= payload_bytes_i;
    end
    if (state == S_PRE) csum <= ip_csum(total_len, ident, ip_src, ip_dst);
    if (state == S_SFD) crc <= 32'hFFFFFFFF;
    else if ((state == S_HDR) || (state == S_PAY) || (state == S_PAD))
      crc <= crc32_byte(crc, tx_byte);
  end

endmodule

// File: tb/tb_rgmii_udp_tx_framer.sv
// Scoreboard bench for rgmii_udp_tx_framer: expected frames are queued at stimulus time
// and a negedge monitor compares every transmitted byte.
module tb_rgmii_udp_tx_framer;
  localparam int IFG = 12;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [47:0] fpga_mac_i, host_mac_i;
  logic [31:0] fpga_ip_i, host_ip_i;
  logic [15:0] fpga_port_i, host_port_i, payload_bytes_i;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  gmii_txd_o;
  logic        gmii_tx_en_o, busy_o, frame_done_o, underrun_o;

  always #4 clk = ~clk;

  rgmii_udp_tx_framer #(.IFG_BYTES(IFG), .TTL(8'h40)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .fpga_mac_i(fpga_mac_i), .host_mac_i(host_mac_i),
    .fpga_ip_i(fpga_ip_i), .host_ip_i(host_ip_i),
    .fpga_port_i(fpga_port_i), .host_port_i(host_port_i),
    .payload_bytes_i(payload_bytes_i),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .gmii_txd_o(gmii_txd_o), .gmii_tx_en_o(gmii_tx_en_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .underrun_o(underrun_o)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pidx = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap[$];
  int rise_cyc[$];
  int done_cyc[$];
  int en_cnt = 0, und_cnt = 0, done_cnt = 0;
  logic en_prev = 1'b0;
  logic [7:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pb(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  function automatic logic [15:0] model_csum(input logic [15:0] tl, input logic [15:0] id,
                                             input logic [31:0] s, input logic [31:0] d);
    int sum;
    sum = 'h4500 + int'(tl) + int'(id) + 'h4000 + 'h4011 + int'(s[31:16]) + int'(s[15:0])
        + int'(d[31:16]) + int'(d[15:0]);
    while ((sum >> 16) != 0) sum = (sum & 'hFFFF) + (sum >> 16);
    return ~sum[15:0];
  endfunction

  function automatic logic [7:0] capb(input int i);
    if (i < cap.size()) return cap[i];
    return 8'hEE;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (gmii_tx_en_o) begin
      en_cnt++;
      cap.push_back(gmii_txd_o);
      if (!en_prev) rise_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h with no expected byte queued", gmii_txd_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("tx_byte", {24'h0, gmii_txd_o}, {24'h0, mon_e});
      end
    end
    if (underrun_o) und_cnt++;
    if (frame_done_o) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    en_prev = gmii_tx_en_o;
  end

  task automatic set_cfg();
    fpga_mac_i  = 48'h02AA_BBCC_DDEE;
    host_mac_i  = 48'h0011_2233_4455;
    fpga_ip_i   = 32'hC0A8_0001;
    host_ip_i   = 32'hC0A8_00C7;
    fpga_port_i = 16'h04D2;
    host_port_i = 16'h162E;
  endtask

  task automatic push16(inout logic [7:0] b[$], input logic [15:0] v);
    b.push_back(v[15:8]);
    b.push_back(v[7:0]);
  endtask

  task automatic push_frame(input int n, input logic [15:0] id, input int off,
                            input int gs, input int gl);
    logic [7:0] b[$];
    logic [31:0] c;
    logic [15:0] tl;
    int k;
    tl = 16'(n + 28);
    for (int i = 5; i >= 0; i--) b.push_back(host_mac_i[8*i +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(fpga_mac_i[8*i +: 8]);
    push16(b, 16'h0800); push16(b, 16'h4500); push16(b, tl); push16(b, id);
    push16(b, 16'h4000); push16(b, 16'h4011);
    push16(b, model_csum(tl, id, fpga_ip_i, host_ip_i));
    push16(b, fpga_ip_i[31:16]); push16(b, fpga_ip_i[15:0]);
    push16(b, host_ip_i[31:16]); push16(b, host_ip_i[15:0]);
    push16(b, fpga_port_i); push16(b, host_port_i);
    push16(b, 16'(n + 8)); push16(b, 16'h0000);
    k = off;
    for (int j = 0; j < n; j++) begin
      if (j >= gs && j < gs + gl) b.push_back(8'h00);
      else begin b.push_back(pb(k)); k++; end
    end
    for (int j = n; j < 18; j++) b.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (b[i]) c = crc_upd(c, b[i]);
    c = ~c;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (b[i]) exp_q.push_back(b[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
  endtask

  // Drives nf frames of n payload bytes; slots gs..gs+gl-1 of each frame are left invalid.
  task automatic run(input int nf, input int n, input int gs, input int gl, input bit scramble);
    int slots, idx, t, d0;
    bit cons;
    slots = 0; idx = 0; t = 0; d0 = done_cnt;
    payload_bytes_i = 16'(n);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = pb(pidx);
    s_axis_tlast  = (n == 1);
    while (done_cnt < d0 + nf && t < 3000) begin
      @(negedge clk);
      cons = s_axis_tvalid && s_axis_tready;
      if (s_axis_tready) slots++;
      @(posedge clk); #1;
      t++;
      if (cons) idx++;
      s_axis_tdata  = pb(pidx + idx);
      s_axis_tvalid = (slots < nf * n) && !((slots % n) >= gs && (slots % n) < gs + gl);
      s_axis_tlast  = s_axis_tvalid && ((slots % n) == n - 1);
      if (scramble && t == 3) begin
        host_ip_i = 32'hDEAD_BEEF; fpga_port_i = 16'hFFFF;
        host_mac_i = 48'h0; payload_bytes_i = 16'd200;
      end
    end
    if (t >= 3000) begin
      n_chk++; n_fail++;
      $display("FAIL run_timeout: got %0d frames done, expected %0d", done_cnt - d0, nf);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    pidx += idx;
  endtask

  task automatic wait_idle();
    repeat (IFG + 4) @(posedge clk);
    #1;
  endtask

  task automatic check_residue(input string name, input int base, input int flen);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = base + 8; i < base + flen; i++) c = crc_upd(c, capb(i));
    check(name, c, 32'hDEBB20E3);
  endtask

  initial begin
    int cb, e0, u0, d0, r0, zc;
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cb, e0, u0, d0, r0, zc;
    rst_i = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0;
    payload_bytes_i = 16'd1;
    set_cfg();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", {24'h0, gmii_txd_o}, 32'h0);
    check("rst_tx_en", {31'h0, gmii_tx_en_o}, 32'h0);
    check("rst_tready", {31'h0, s_axis_tready}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_done", {31'h0, frame_done_o}, 32'h0);
    check("rst_underrun", {31'h0, underrun_o}, 32'h0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Frame 1: N=87, identification 0
    cb = cap.size(); e0 = en_cnt;
    push_frame(87, 16'h0000, pidx, 1000, 0);
    run(1, 87, 1000, 0, 1'b0);
    check("t1_busy_in_ifg", {31'h0, busy_o}, 32'h1);
    check("t1_en_in_ifg", {31'h0, gmii_tx_en_o}, 32'h0);
    wait_idle();
    check("t1_busy_after_ifg", {31'h0, busy_o}, 32'h0);
    check("t1_en_cycles", en_cnt - e0, 141);
    check("t1_ident", {capb(cb+26), capb(cb+27)}, 32'h0000);
    check("t1_hdr_csum", {capb(cb+32), capb(cb+33)}, 32'hB861);
    check("t1_total_len", {capb(cb+24), capb(cb+25)}, 32'h0073);
    check("t1_udp_len", {capb(cb+46), capb(cb+47)}, 32'h005F);
    check_residue("t1_crc_residue", cb, 141);
    check("t1_queue_empty", exp_q.size(), 0);

    // Frame 2: N=5 with pad, config scrambled mid-frame, identification 1
    cb = cap.size(); e0 = en_cnt;
    push_frame(5, 16'h0001, pidx, 1000, 0);
    run(1, 5, 1000, 0, 1'b1);
    wait_idle();
    set_cfg();
    check("t2_en_cycles", en_cnt - e0, 72);
    check("t2_total_len", {capb(cb+24), capb(cb+25)}, 32'h0021);
    check("t2_ident", {capb(cb+26), capb(cb+27)}, 32'h0001);
    zc = 0;
    for (int j = 0; j < 13; j++) if (capb(cb + 55 + j) == 8'h00) zc++;
    check("t2_pad_zeros", zc, 13);
    check_residue("t2_crc_residue", cb, 72);
    check("t2_queue_empty", exp_q.size(), 0);

    // Frame 3: N=64 with a three-slot underrun
    cb = cap.size(); e0 = en_cnt; u0 = und_cnt;
    push_frame(64, 16'h0002, pidx, 20, 3);
    run(1, 64, 20, 3, 1'b0);
    wait_idle();
    check("t3_underruns", und_cnt - u0, 3);
    check("t3_en_cycles", en_cnt - e0, 118);
    for (int j = 20; j < 23; j++) check("t3_gap_byte", {24'h0, capb(cb + 50 + j)}, 32'h0);
    check_residue("t3_crc_residue", cb, 118);
    check("t3_queue_empty", exp_q.size(), 0);

    // Reset during the header
    d0 = done_cnt;
    push_frame(30, 16'h0003, pidx, 1000, 0);
    payload_bytes_i = 16'd30;
    s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("t4_in_header_en", {31'h0, gmii_tx_en_o}, 32'h1);
    rst_i = 1'b1;
    s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    check("t4_rst_tx_en", {31'h0, gmii_tx_en_o}, 32'h0);
    check("t4_rst_busy", {31'h0, busy_o}, 32'h0);
    check("t4_rst_tready", {31'h0, s_axis_tready}, 32'h0);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t4_no_done", done_cnt - d0, 0);

    // Two back-to-back frames after reset: identification 0 then 1
    cb = cap.size(); e0 = en_cnt; d0 = done_cyc.size(); r0 = rise_cyc.size();
    push_frame(5, 16'h0000, pidx, 1000, 0);
    push_frame(5, 16'h0001, pidx + 5, 1000, 0);
    run(2, 5, 1000, 0, 1'b0);
    wait_idle();
    check("t5_en_cycles", en_cnt - e0, 144);
    check("t5_ident_a", {capb(cb+26), capb(cb+27)}, 32'h0000);
    check("t5_ident_b", {capb(cb+72+26), capb(cb+72+27)}, 32'h0001);
    if (rise_cyc.size() >= r0 + 2 && done_cyc.size() >= d0 + 1)
      check("t5_ifg_gap", rise_cyc[r0 + 1] - done_cyc[d0], IFG + 1);
    else begin
      n_chk++; n_fail++;
      $display("FAIL t5_ifg_gap: got %0d rises, expected 2", rise_cyc.size() - r0);
    end
    check_residue("t5_crc_residue_a", cb, 72);
    check_residue("t5_crc_residue_b", cb + 72, 72);
    check("t5_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
